// File: rtl/ascon_out_collector_if.sv
// ascon_out_collector_if: core output strobes and register-file readback bus of the collector.
// Optional O_trig exists only when ASCON_COLLECT_TRIG_EN is defined.
interface ascon_out_collector_if #(
   parameter int pCT_WIDTH  = 128,
   parameter int pTAG_WIDTH = 128,
   parameter int pDEPTH     = 4
);
   localparam int CW = $clog2(pDEPTH) + 1;
   logic                  I_ciphertext_valid;
   logic [pCT_WIDTH-1:0]  I_ciphertext;
   logic                  I_last;
   logic [4:0]            I_valid_bytes;
   logic                  I_ready_tag;
   logic [pTAG_WIDTH-1:0] I_tag;
   logic                  I_rd_req;
   logic [pCT_WIDTH-1:0]  O_ct_data;
   logic [4:0]            O_ct_bytes;
   logic [CW-1:0]         O_count;
   logic                  O_empty;
   logic                  O_full;
   logic                  O_stall;
   logic [pTAG_WIDTH-1:0] O_tag;
   logic                  O_tag_valid;
   logic                  O_done;
   logic [1:0]            O_err;
`ifdef ASCON_COLLECT_TRIG_EN
   logic                  O_trig;
   modport master (
      output I_ciphertext_valid, I_ciphertext, I_last, I_valid_bytes, I_ready_tag, I_tag, I_rd_req,
      input  O_ct_data, O_ct_bytes, O_count, O_empty, O_full, O_stall, O_tag, O_tag_valid, O_done, O_err, O_trig
   );
   modport slave (
      input  I_ciphertext_valid, I_ciphertext, I_last, I_valid_bytes, I_ready_tag, I_tag, I_rd_req,
      output O_ct_data, O_ct_bytes, O_count, O_empty, O_full, O_stall, O_tag, O_tag_valid, O_done, O_err, O_trig
   );
`else
   modport master (
      output I_ciphertext_valid, I_ciphertext, I_last, I_valid_bytes, I_ready_tag, I_tag, I_rd_req,
      input  O_ct_data, O_ct_bytes, O_count, O_empty, O_full, O_stall, O_tag, O_tag_valid, O_done, O_err
   );
   modport slave (
      input  I_ciphertext_valid, I_ciphertext, I_last, I_valid_bytes, I_ready_tag, I_tag, I_rd_req,
      output O_ct_data, O_ct_bytes, O_count, O_empty, O_full, O_stall, O_tag, O_tag_valid, O_done, O_err
   );
`endif
endinterface

// File: rtl/ascon_out_collector.sv
// ascon_out_collector: buffers ciphertext blocks and the tag from the core for slow register readback.
// Define ASCON_COLLECT_TRIG_EN to add the O_trig scope-window output.
module ascon_out_collector #(
   parameter int pCT_WIDTH  = 128,
   parameter int pTAG_WIDTH = 128,
   parameter int pDEPTH     = 4
) (
   input logic                  crypt_clk,
   input logic                  resetn,
   input logic                  clear_i,
   ascon_out_collector_if.slave bus
);
   localparam int AW = $clog2(pDEPTH);
   localparam int CW = AW + 1;
   localparam int NB = pCT_WIDTH / 8;
   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_TAG, S_DONE} state_t;
   state_t                state;
   logic [pCT_WIDTH-1:0]  mem [pDEPTH];
   logic [4:0]            bytes_mem [pDEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [CW-1:0]         count, count_next;
   logic [pCT_WIDTH-1:0]  wdata;
   logic [4:0]            wbytes;
   logic [pTAG_WIDTH-1:0] tag;
   logic [1:0]            err;
   logic                  tag_prev, tag_edge, tag_valid, done;
   logic                  push, empty, full, do_pop, do_write, overflow, partial;
   assign push       = bus.I_ciphertext_valid;
   assign empty      = count == '0;
   assign full       = count == CW'(pDEPTH);
   assign do_pop     = bus.I_rd_req && !empty;
   assign do_write   = push && (!full || do_pop);
   assign overflow   = push && full && !do_pop;
   assign count_next = count + CW'(do_write) - CW'(do_pop);
   assign tag_edge   = bus.I_ready_tag && !tag_prev;
   assign partial    = bus.I_last && bus.I_valid_bytes != 5'd0 && bus.I_valid_bytes < 5'd16;
   // Byte 0 is the most significant byte; trailing bytes of a short final block read as zero.
   always_comb begin
      wdata  = bus.I_ciphertext;
      wbytes = partial ? bus.I_valid_bytes : 5'd16;
      for (int i = 0; i < NB; i++)
         if (partial && i >= int'(bus.I_valid_bytes)) wdata[pCT_WIDTH-1-8*i -: 8] = 8'h00;
   end
   always_ff @(posedge crypt_clk)
      if (do_write && !clear_i) begin
         mem[wr_ptr]       <= wdata;
         bytes_mem[wr_ptr] <= wbytes;
      end
   always_ff @(posedge crypt_clk or negedge resetn)
      if (!resetn) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         tag       <= '0;
         tag_valid <= 1'b0;
         tag_prev  <= 1'b0;
         done      <= 1'b0;
         err       <= 2'b00;
         state     <= S_IDLE;
      end else if (clear_i) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         tag       <= '0;
         tag_valid <= 1'b0;
         tag_prev  <= 1'b0;
         done      <= 1'b0;
         err       <= 2'b00;
         state     <= S_IDLE;
      end else begin
         tag_prev <= bus.I_ready_tag;
         count    <= count_next;
         if (do_write) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         if (overflow) err[0] <= 1'b1;
         if (tag_edge && (state == S_IDLE || state == S_COLLECT)) begin
            tag       <= bus.I_tag;
            tag_valid <= 1'b1;
         end else if (tag_edge) err[1] <= 1'b1;
         // Done tracks the post-update occupancy so it rises together with O_empty.
         case (state)
            S_IDLE:    state <= tag_edge ? S_TAG : push ? S_COLLECT : S_IDLE;
            S_COLLECT: state <= tag_edge ? S_TAG : S_COLLECT;
            S_TAG:     if (count_next == '0) begin
               state <= S_DONE;
               done  <= 1'b1;
            end
            S_DONE:    if (push) begin
               state <= S_TAG;
               done  <= 1'b0;
            end
            default:   state <= S_IDLE;
         endcase
      end
`ifdef ASCON_COLLECT_TRIG_EN
   logic trig;
   always_ff @(posedge crypt_clk or negedge resetn)
      if (!resetn) trig <= 1'b0;
      else if (clear_i) trig <= 1'b0;
      else if (state == S_IDLE && (push || tag_edge)) trig <= 1'b1;
      else if (tag_valid) trig <= 1'b0;
   assign bus.O_trig = trig;
`endif
   assign bus.O_ct_data   = empty ? '0 : mem[rd_ptr];
   assign bus.O_ct_bytes  = empty ? 5'd0 : bytes_mem[rd_ptr];
   assign bus.O_count     = count;
   assign bus.O_empty     = empty;
   assign bus.O_full      = full;
   assign bus.O_stall     = count >= CW'(pDEPTH - 1);
   assign bus.O_tag       = tag;
   assign bus.O_tag_valid = tag_valid;
   assign bus.O_done      = done;
   assign bus.O_err       = err;
endmodule

// File: tb/tb_ascon_out_collector.sv
// tb_ascon_out_collector: directed self-checking bench for the ciphertext/tag collector.
module tb_ascon_out_collector;
   localparam logic [127:0] B  = 128'h00112233445566778899AABBCCDDEEFF;
   localparam logic [127:0] T  = 128'hDEADBEEF000000000000000000000123;
   localparam logic [127:0] T2 = 128'hCAFEF00D0000000000000000000000AA;
   logic clk, resetn, clear;
   int vec, errs;
   ascon_out_collector_if #(.pCT_WIDTH(128), .pTAG_WIDTH(128), .pDEPTH(4)) bus ();
   ascon_out_collector #(.pCT_WIDTH(128), .pTAG_WIDTH(128), .pDEPTH(4)) dut (
      .crypt_clk(clk), .resetn(resetn), .clear_i(clear), .bus(bus)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
   function automatic logic [127:0] blk(input int i);
      logic [7:0] b;
      b = 8'(i) + 8'h10;
      return {16{b}};
   endfunction
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic push(input logic [127:0] d, input logic last, input logic [4:0] vb);
      bus.I_ciphertext_valid = 1'b1;
      bus.I_ciphertext = d;
      bus.I_last = last;
      bus.I_valid_bytes = vb;
      step();
      bus.I_ciphertext_valid = 1'b0;
      bus.I_last = 1'b0;
      bus.I_valid_bytes = 5'd0;
   endtask
   task automatic pop();
      bus.I_rd_req = 1'b1;
      step();
      bus.I_rd_req = 1'b0;
   endtask
   task automatic do_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask
   task automatic test_reset();
      resetn = 1'b0;
      step();
      step();
      resetn = 1'b1;
      step();
      vec++; if (bus.O_count !== 3'd0) begin errs++; $display("FAIL reset_count: got %0d want 0", bus.O_count); end
      vec++; if (bus.O_empty !== 1'b1 || bus.O_full !== 1'b0 || bus.O_stall !== 1'b0) begin errs++; $display("FAIL reset_flags: got e%b f%b s%b want e1 f0 s0", bus.O_empty, bus.O_full, bus.O_stall); end
      vec++; if (bus.O_ct_data !== 128'h0 || bus.O_ct_bytes !== 5'd0) begin errs++; $display("FAIL reset_head: got %h/%0d want 0/0", bus.O_ct_data, bus.O_ct_bytes); end
      vec++; if (bus.O_tag !== 128'h0 || bus.O_tag_valid !== 1'b0 || bus.O_done !== 1'b0 || bus.O_err !== 2'b00) begin errs++; $display("FAIL reset_tag: got tag %h v%b d%b err %b want 0 0 0 00", bus.O_tag, bus.O_tag_valid, bus.O_done, bus.O_err); end
   endtask
   task automatic test_push();
      push(B, 1'b0, 5'd0);
      vec++; if (bus.O_count !== 3'd1 || bus.O_empty !== 1'b0) begin errs++; $display("FAIL push_count: got %0d e%b want 1 e0", bus.O_count, bus.O_empty); end
      vec++; if (bus.O_ct_data !== B) begin errs++; $display("FAIL push_data: got %h want %h", bus.O_ct_data, B); end
      vec++; if (bus.O_ct_bytes !== 5'd16) begin errs++; $display("FAIL push_bytes: got %0d want 16", bus.O_ct_bytes); end
      vec++; if (bus.O_done !== 1'b0 || bus.O_stall !== 1'b0) begin errs++; $display("FAIL push_status: got d%b s%b want d0 s0", bus.O_done, bus.O_stall); end
      pop();
      vec++; if (bus.O_count !== 3'd0 || bus.O_ct_data !== 128'h0) begin errs++; $display("FAIL push_pop: got %0d %h want 0 0", bus.O_count, bus.O_ct_data); end
   endtask
   task automatic test_mask();
      do_clear();
      push(B, 1'b1, 5'd5);
      vec++; if (bus.O_ct_data !== 128'h00112233440000000000000000000000) begin errs++; $display("FAIL mask5_data: got %h want 00112233440000000000000000000000", bus.O_ct_data); end
      vec++; if (bus.O_ct_bytes !== 5'd5) begin errs++; $display("FAIL mask5_bytes: got %0d want 5", bus.O_ct_bytes); end
      pop();
      push(B, 1'b1, 5'd15);
      vec++; if (bus.O_ct_data !== 128'h00112233445566778899AABBCCDDEE00 || bus.O_ct_bytes !== 5'd15) begin errs++; $display("FAIL mask15: got %h/%0d want 00112233445566778899AABBCCDDEE00/15", bus.O_ct_data, bus.O_ct_bytes); end
      pop();
      push(B, 1'b1, 5'd0);
      vec++; if (bus.O_ct_data !== B || bus.O_ct_bytes !== 5'd16) begin errs++; $display("FAIL mask0: got %h/%0d want %h/16", bus.O_ct_data, bus.O_ct_bytes, B); end
      pop();
      push(B, 1'b1, 5'd16);
      vec++; if (bus.O_ct_data !== B || bus.O_ct_bytes !== 5'd16) begin errs++; $display("FAIL mask16: got %h/%0d want %h/16", bus.O_ct_data, bus.O_ct_bytes, B); end
      pop();
   endtask
   task automatic test_overflow();
      do_clear();
      for (int i = 0; i < 3; i++) push(blk(i), 1'b0, 5'd0);
      vec++; if (bus.O_stall !== 1'b1 || bus.O_full !== 1'b0 || bus.O_count !== 3'd3) begin errs++; $display("FAIL ovf_stall3: got s%b f%b c%0d want s1 f0 c3", bus.O_stall, bus.O_full, bus.O_count); end
      push(blk(3), 1'b0, 5'd0);
      push(blk(4), 1'b0, 5'd0);
      vec++; if (bus.O_full !== 1'b1 || bus.O_count !== 3'd4) begin errs++; $display("FAIL ovf_full: got f%b c%0d want f1 c4", bus.O_full, bus.O_count); end
      vec++; if (bus.O_err !== 2'b01) begin errs++; $display("FAIL ovf_err: got %b want 01", bus.O_err); end
      for (int i = 0; i < 4; i++) begin
         vec++; if (bus.O_ct_data !== blk(i)) begin errs++; $display("FAIL ovf_order%0d: got %h want %h", i, bus.O_ct_data, blk(i)); end
         pop();
      end
      vec++; if (bus.O_empty !== 1'b1 || bus.O_count !== 3'd0) begin errs++; $display("FAIL ovf_drained: got e%b c%0d want e1 c0", bus.O_empty, bus.O_count); end
      pop();
      vec++; if (bus.O_count !== 3'd0 || bus.O_err !== 2'b01) begin errs++; $display("FAIL pop_empty: got c%0d err %b want c0 err 01", bus.O_count, bus.O_err); end
   endtask
   task automatic test_full_push_pop();
      do_clear();
      for (int i = 0; i < 4; i++) push(blk(i), 1'b0, 5'd0);
      bus.I_rd_req = 1'b1;
      push(blk(4), 1'b0, 5'd0);
      bus.I_rd_req = 1'b0;
      vec++; if (bus.O_count !== 3'd4 || bus.O_ct_data !== blk(1)) begin errs++; $display("FAIL fullpp_head: got c%0d %h want c4 %h", bus.O_count, bus.O_ct_data, blk(1)); end
      vec++; if (bus.O_err !== 2'b00) begin errs++; $display("FAIL fullpp_err: got %b want 00", bus.O_err); end
      for (int i = 1; i < 5; i++) begin
         vec++; if (bus.O_ct_data !== blk(i)) begin errs++; $display("FAIL fullpp_order%0d: got %h want %h", i, bus.O_ct_data, blk(i)); end
         pop();
      end
      do_clear();
      bus.I_rd_req = 1'b1;
      push(blk(7), 1'b0, 5'd0);
      bus.I_rd_req = 1'b0;
      vec++; if (bus.O_count !== 3'd1 || bus.O_ct_data !== blk(7)) begin errs++; $display("FAIL emptypp: got c%0d %h want c1 %h", bus.O_count, bus.O_ct_data, blk(7)); end
   endtask
   task automatic test_tag();
      do_clear();
      push(B, 1'b0, 5'd0);
      bus.I_tag = T;
      bus.I_ready_tag = 1'b1;
      step();
      vec++; if (bus.O_tag_valid !== 1'b1 || bus.O_tag !== T) begin errs++; $display("FAIL tag_latch: got v%b %h want v1 %h", bus.O_tag_valid, bus.O_tag, T); end
      vec++; if (bus.O_done !== 1'b0) begin errs++; $display("FAIL tag_notdone: got %b want 0", bus.O_done); end
      pop();
      vec++; if (bus.O_done !== 1'b1 || bus.O_empty !== 1'b1) begin errs++; $display("FAIL tag_done: got d%b e%b want d1 e1", bus.O_done, bus.O_empty); end
      bus.I_ready_tag = 1'b0;
      step();
      bus.I_tag = T2;
      bus.I_ready_tag = 1'b1;
      step();
      vec++; if (bus.O_err !== 2'b10 || bus.O_tag !== T) begin errs++; $display("FAIL tag_overrun: got err %b %h want err 10 %h", bus.O_err, bus.O_tag, T); end
      push(blk(9), 1'b0, 5'd0);
      vec++; if (bus.O_done !== 1'b0 || bus.O_count !== 3'd1) begin errs++; $display("FAIL late_block: got d%b c%0d want d0 c1", bus.O_done, bus.O_count); end
      pop();
      vec++; if (bus.O_done !== 1'b1) begin errs++; $display("FAIL late_done: got %b want 1", bus.O_done); end
      bus.I_ready_tag = 1'b0;
      step();
      do_clear();
      bus.I_tag = T2;
      bus.I_ready_tag = 1'b1;
      step();
      vec++; if (bus.O_tag_valid !== 1'b1 || bus.O_done !== 1'b0 || bus.O_err !== 2'b00) begin errs++; $display("FAIL empty_msg_tag: got v%b d%b err %b want v1 d0 err 00", bus.O_tag_valid, bus.O_done, bus.O_err); end
      step();
      vec++; if (bus.O_done !== 1'b1 || bus.O_tag !== T2) begin errs++; $display("FAIL empty_msg_done: got d%b %h want d1 %h", bus.O_done, bus.O_tag, T2); end
      bus.I_ready_tag = 1'b0;
      step();
      do_clear();
      bus.I_tag = T;
      bus.I_ready_tag = 1'b1;
      push(B, 1'b0, 5'd0);
      vec++; if (bus.O_count !== 3'd1 || bus.O_tag_valid !== 1'b1 || bus.O_tag !== T) begin errs++; $display("FAIL push_and_tag: got c%0d v%b %h want c1 v1 %h", bus.O_count, bus.O_tag_valid, bus.O_tag, T); end
      pop();
      vec++; if (bus.O_done !== 1'b1) begin errs++; $display("FAIL push_and_tag_done: got %b want 1", bus.O_done); end
      bus.I_ready_tag = 1'b0;
      step();
   endtask
   task automatic test_async_reset();
      do_clear();
      push(blk(1), 1'b0, 5'd0);
      push(blk(2), 1'b0, 5'd0);
      bus.I_tag = T;
      bus.I_ready_tag = 1'b1;
      step();
      bus.I_ready_tag = 1'b0;
      vec++; if (bus.O_count !== 3'd2 || bus.O_tag_valid !== 1'b1) begin errs++; $display("FAIL areset_pre: got c%0d v%b want c2 v1", bus.O_count, bus.O_tag_valid); end
      #2 resetn = 1'b0;
      #1;
      vec++; if (bus.O_count !== 3'd0 || bus.O_empty !== 1'b1 || bus.O_ct_data !== 128'h0 || bus.O_ct_bytes !== 5'd0) begin errs++; $display("FAIL areset_fifo: got c%0d e%b %h/%0d want c0 e1 0/0", bus.O_count, bus.O_empty, bus.O_ct_data, bus.O_ct_bytes); end
      vec++; if (bus.O_tag !== 128'h0 || bus.O_tag_valid !== 1'b0 || bus.O_done !== 1'b0 || bus.O_err !== 2'b00 || bus.O_stall !== 1'b0) begin errs++; $display("FAIL areset_tag: got %h v%b d%b err %b s%b want 0 0 0 00 0", bus.O_tag, bus.O_tag_valid, bus.O_done, bus.O_err, bus.O_stall); end
      step();
      resetn = 1'b1;
      step();
   endtask
   initial begin
      vec = 0;
      errs = 0;
      resetn = 1'b0;
      clear = 1'b0;
      bus.I_ciphertext_valid = 1'b0;
      bus.I_ciphertext = '0;
      bus.I_last = 1'b0;
      bus.I_valid_bytes = 5'd0;
      bus.I_ready_tag = 1'b0;
      bus.I_tag = '0;
      bus.I_rd_req = 1'b0;
      test_reset();
      test_push();
      test_mask();
      test_overflow();
      test_full_push_pop();
      test_tag();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
